layer2_disc_arbiter: RTL and testbench
======================================

Name: layer2_disc_arbiter

Overview:
- Shares one `layer2_discriminator` engine (128 Q8.8 in -> 32 Q8.8 out) between two requesters: the real-sample path (req 0) and the generated-sample path (req 1).
- Arbitrates round-robin, latches the winner's input vector and pulses the engine's start.
- Waits for the engine's done, captures the 32 outputs and returns them with the requester ID over a valid/ready response port.
- Sits between the discriminator layer-1 output buffers and the layer-3 scheduler.

Parameters:
- N_IN, 128, input elements per job
- N_OUT, 32, output elements per job
- DW, 16, element width (signed Q8.8)
- TIMEOUT_CYCLES, 4096, engine watchdog limit (used only with LAYER2_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester job request (level; held until ack)
- in0_flat  in  N_IN*DW  requester 0 input vector, element i at [(i+1)*DW-1 -: DW]
- in1_flat  in  N_IN*DW  requester 1 input vector, same packing
- ack  out  2  one-hot, 1-cycle pulse: input captured, requester may drop req
- busy  out  1  high whenever state != IDLE
- eng_start  out  1  1-cycle start pulse to engine
- eng_in_flat  out  N_IN*DW  registered input to engine
- eng_out_flat  in  N_OUT*DW  engine output
- eng_done  in  1  engine done (level; may stay high between jobs)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that owns the response
- resp_data  out  N_OUT*DW  captured engine output
- resp_err  out  1  timeout flag (always 0 without LAYER2_ARB_TIMEOUT_EN)

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; ack, eng_start, resp_valid, resp_id, resp_err, busy = 0; eng_in_flat, resp_data = 0; last_grant=1, so requester 0 wins the first tie; done_q=0.
- FSM states: IDLE, LAUNCH, BUSY, DELIVER.
- IDLE:
  - If any req bit is set, pick the winner: the sole requester; if both, the one != last_grant.
  - Register the winner's input into eng_in_flat, set grant_id, update last_grant, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - eng_start=1 and ack[grant_id]=1.
  - eng_done is ignored.
  - Go to BUSY.
- BUSY:
  - done_q registers eng_done every cycle.
  - A done is accepted only on a rising edge (eng_done=1 and done_q=0), so a done level left over from the previous job is not taken as completion.
  - On accepted done: resp_data <= eng_out_flat, resp_id <= grant_id, resp_valid <= 1, go to DELIVER.
- DELIVER:
  - resp_valid, resp_id and resp_data are held stable while resp_ready=0.
  - On resp_valid and resp_ready: resp_valid <= 0, go to IDLE.
  - No new arbitration until the next cycle: back-to-back jobs cost 1 IDLE cycle.
- Latency: req sampled in IDLE at cycle 0 -> eng_start/ack at cycle 1 -> resp_valid 1 cycle after the engine's done rising edge.
- Requester rules:
  - A requester must hold req and its input stable until it sees ack.
  - After ack, input changes have no effect; the job is already latched.
  - req still high one cycle after ack is treated as a new job request.
- A req deasserted before ack is simply not served; there is no error.
- Response ordering is strictly one job in flight, so responses return in grant order.
- Starvation: with both req held continuously, grants alternate 0,1,0,1.
- Reset mid-job: all state cleared immediately, any response in flight is dropped, and the engine is not re-started.

Optional Feature:
- Macro LAYER2_ARB_TIMEOUT_EN.
- When defined: a counter clears on entry to BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES with no done edge:
  - resp_data <= 0, resp_err <= 1, resp_valid <= 1, go to DELIVER;
  - resp_err clears on handshake.
- When undefined: no counter logic, resp_err tied to 0, BUSY waits indefinitely.

Decomposition:
- Shared package `disc_pkg`:
  - constants DISC_L2_N_IN=128, DISC_L2_N_OUT=32, Q_DW=16;
  - state enum `arb_state_t` {IDLE, LAUNCH, BUSY, DELIVER};
  - requester ID constants REQ_REAL=0, REQ_FAKE=1.
- One natural sub-module: `rr_arb2`, the 2-way round-robin picker (req, last_grant -> grant_valid, grant_id). The FSM, latches and watchdog stay in the top module.

Test Plan:
- Single request:
  - Stimulus: req=01, in0 all 0x0100, engine model asserts done 40 cycles after start with out=pattern A.
  - Required: ack=01 one cycle after req; exactly one eng_start pulse; resp_valid with resp_id=0, resp_data=A.
- Tie and alternation:
  - Stimulus: req=11 held, with distinct inputs.
  - Required: grant order 0,1,0,1; each eng_in_flat matches the granted input; 1 IDLE cycle between jobs.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles after resp_valid.
  - Required: resp_data/resp_id stable; no second eng_start while req=10 is pending; accept then launch requester 1.
- Sticky done:
  - Stimulus: engine keeps eng_done=1 from the previous job into the next LAUNCH/BUSY, then drops and re-raises it after 20 cycles.
  - Required: completion only at the re-raise edge.
- Reset mid-BUSY:
  - Stimulus: rst_n=0 for 2 cycles during BUSY.
  - Required: all outputs 0 asynchronously; no resp_valid; next tie grants requester 0.
- Timeout (LAYER2_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64):
  - Stimulus: engine never asserts done.
  - Required: resp_valid with resp_err=1 and resp_data=0 at BUSY cycle 64.

Source files
------------

// File: rtl/disc_pkg.sv
// Shared discriminator constants, requester IDs and the layer-2 arbiter state type.
package disc_pkg;
  localparam int DISC_L2_N_IN  = 128;
  localparam int DISC_L2_N_OUT = 32;
  localparam int Q_DW          = 16;

  localparam logic REQ_REAL = 1'b0;
  localparam logic REQ_FAKE = 1'b1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DELIVER} arb_state_t;
endpackage

// File: rtl/layer2_disc_arbiter_if.sv
// Request, engine and response bundle of the layer-2 discriminator arbiter.
interface layer2_disc_arbiter_if
  import disc_pkg::*;
#(
  parameter int N_IN  = DISC_L2_N_IN,
  parameter int N_OUT = DISC_L2_N_OUT,
  parameter int DW    = Q_DW
) ();
  logic [1:0]          req;
  logic [N_IN*DW-1:0]  in0_flat;
  logic [N_IN*DW-1:0]  in1_flat;
  logic [1:0]          ack;
  logic                busy;
  logic                eng_start;
  logic [N_IN*DW-1:0]  eng_in_flat;
  logic [N_OUT*DW-1:0] eng_out_flat;
  logic                eng_done;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_id;
  logic [N_OUT*DW-1:0] resp_data;
  logic                resp_err;

  modport slave (
    input  req, in0_flat, in1_flat, eng_out_flat, eng_done, resp_ready,
    output ack, busy, eng_start, eng_in_flat, resp_valid, resp_id, resp_data, resp_err
  );
  modport master (
    output req, in0_flat, in1_flat, eng_out_flat, eng_done, resp_ready,
    input  ack, busy, eng_start, eng_in_flat, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/layer2_disc_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_arb2
  import disc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req;
  assign grant_id    = (req == 2'b11) ? ~last_grant : (req[1] ? REQ_FAKE : REQ_REAL);
endmodule

// File: rtl/layer2_disc_arbiter.sv
// Shares one layer-2 discriminator engine between the real and generated sample paths.
// Optional engine watchdog: define LAYER2_ARB_TIMEOUT_EN.
module layer2_disc_arbiter
  import disc_pkg::*;
#(
  parameter int N_IN  = DISC_L2_N_IN,
  parameter int N_OUT = DISC_L2_N_OUT,
  parameter int DW    = Q_DW
`ifdef LAYER2_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  layer2_disc_arbiter_if.slave bus
);
  arb_state_t          state, state_d;
  logic                grant_valid, grant_sel, grant_id, last_grant, done_q;
  logic                done_edge, timeout, eng_start_c;
  logic [1:0]          ack_c;
  logic [N_IN*DW-1:0]  eng_in_q;
  logic [N_OUT*DW-1:0] resp_data_q;
  logic                resp_valid_q, resp_id_q;

  rr_arb2 u_rr (.req(bus.req), .last_grant(last_grant), .grant_valid(grant_valid), .grant_id(grant_sel));

  // A done level left high from the previous job must not complete the new one.
  assign done_edge = bus.eng_done & ~done_q;

`ifdef LAYER2_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          resp_err_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                wd_cnt <= '0;
    else if (state == LAUNCH)  wd_cnt <= '0;
    else if (state == BUSY)    wd_cnt <= wd_cnt + 1'b1;

  assign timeout      = (state == BUSY) && !done_edge && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign bus.resp_err = resp_err_q;
`else
  assign timeout      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;

  always_comb begin
    state_d     = state;
    eng_start_c = 1'b0;
    ack_c       = 2'b00;
    unique case (state)
      IDLE:    if (grant_valid) state_d = LAUNCH;
      LAUNCH: begin
        eng_start_c = 1'b1;
        ack_c       = grant_id ? 2'b10 : 2'b01;
        state_d     = BUSY;
      end
      BUSY:    if (done_edge || timeout) state_d = DELIVER;
      DELIVER: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done_q       <= 1'b0;
      eng_in_q     <= '0;
      grant_id     <= REQ_REAL;
      last_grant   <= REQ_FAKE;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef LAYER2_ARB_TIMEOUT_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      done_q <= bus.eng_done;
      if (state == IDLE && grant_valid) begin
        eng_in_q   <= grant_sel ? bus.in1_flat : bus.in0_flat;
        grant_id   <= grant_sel;
        last_grant <= grant_sel;
      end
      if (state == BUSY && done_edge) begin
        resp_data_q  <= bus.eng_out_flat;
        resp_id_q    <= grant_id;
        resp_valid_q <= 1'b1;
      end
`ifdef LAYER2_ARB_TIMEOUT_EN
      if (timeout) begin
        resp_data_q  <= '0;
        resp_id_q    <= grant_id;
        resp_valid_q <= 1'b1;
        resp_err_q   <= 1'b1;
      end
      if (state == DELIVER && bus.resp_ready) resp_err_q <= 1'b0;
`endif
      if (state == DELIVER && bus.resp_ready) resp_valid_q <= 1'b0;
    end

  assign bus.ack         = ack_c;
  assign bus.eng_start   = eng_start_c;
  assign bus.busy        = (state != IDLE);
  assign bus.eng_in_flat = eng_in_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_data   = resp_data_q;
endmodule

// File: tb/tb_layer2_disc_arbiter.sv
// Bench for layer2_disc_arbiter: vector table, corner-case sequences, randomized traffic vs. a rule model.
module tb_layer2_disc_arbiter;
  localparam int N_IN = 128, N_OUT = 32, DW = 16;
  typedef logic [N_IN*DW-1:0]  vin_t;
  typedef logic [N_OUT*DW-1:0] vout_t;
  typedef struct { logic [1:0] rq; int exp_id; } tv_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  layer2_disc_arbiter_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

`ifdef LAYER2_ARB_TIMEOUT_EN
  layer2_disc_arbiter #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .TIMEOUT_CYCLES(64))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  layer2_disc_arbiter #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int vecs = 0, errs = 0;
  int starts = 0, exp_starts = 0;
  int eng_lat = 5, eng_hold = 0;
  bit eng_sticky = 0, eng_never = 0, eng_rand = 0;

  task automatic chk(string name, vin_t act, vin_t exp);
    int k;
    vecs++;
    if (act !== exp) begin
      errs++;
      k = 0;
      for (int i = N_IN - 1; i >= 0; i--) if (act[i*DW +: DW] !== exp[i*DW +: DW]) k = i;
      $display("FAIL %s: elem %0d got %h want %h", name, k, act[k*DW +: DW], exp[k*DW +: DW]);
    end
  endtask

  // Engine behaviour: out[j] = in[j] + in[j+N_OUT], 16-bit wrap.
  function automatic vout_t efun(vin_t v);
    vout_t o;
    for (int j = 0; j < N_OUT; j++) o[j*DW +: DW] = v[j*DW +: DW] + v[(j+N_OUT)*DW +: DW];
    return o;
  endfunction

  function automatic vin_t mkvec(int seed);
    vin_t v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'(seed * 256 + i);
    return v;
  endfunction

  function automatic vin_t rndvec();
    vin_t v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic vin_t fillvec(logic [DW-1:0] e);
    vin_t v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = e;
    return v;
  endfunction

  always @(posedge clk) if (bus.eng_start === 1'b1) starts <= starts + 1;

  // Engine model: done comes lat cycles after start (after an optional hold of the old level).
  initial begin
    int   lat;
    vin_t cap;
    bus.eng_done = 1'b0;
    bus.eng_out_flat = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1 && !eng_never) begin
        cap = bus.eng_in_flat;
        lat = eng_rand ? int'($urandom_range(2, 30)) : eng_lat;
        repeat (eng_hold) @(negedge clk);
        bus.eng_done = 1'b0;
        repeat (lat) @(negedge clk);
        bus.eng_out_flat = efun(cap);
        bus.eng_done = 1'b1;
        if (!eng_sticky) begin @(negedge clk); bus.eng_done = 1'b0; end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // One job from an IDLE negedge through the response handshake.
  task automatic run_job(string tag, logic [1:0] rq, logic [1:0] nxt, int exp_id,
                         int lat, int hold, bit sticky, int bp, vin_t v0, vin_t v1);
    int   n;
    vin_t vw;
    vw = exp_id ? v1 : v0;
    eng_lat = lat; eng_hold = hold; eng_sticky = sticky;
    bus.in0_flat = v0; bus.in1_flat = v1; bus.req = rq;
    @(negedge clk);
    chk({tag, " ack"}, {bus.busy, bus.eng_start, bus.ack}, {2'b11, (exp_id ? 2'b10 : 2'b01)});
    chk({tag, " eng_in"}, bus.eng_in_flat, vw);
    exp_starts++;
    bus.req = nxt; bus.in0_flat = ~v0; bus.in1_flat = ~v1;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, hold + lat + 1);
    chk({tag, " id/err"}, {bus.resp_id, bus.resp_err}, {exp_id[0], 1'b0});
    chk({tag, " data"}, bus.resp_data, efun(vw));
    chk({tag, " starts"}, starts, exp_starts);
    bus.resp_ready = 1'b0;
    if (bp > 0) begin
      repeat (bp) @(negedge clk);
      chk({tag, " held"}, {bus.resp_valid, bus.resp_id, bus.resp_data}, {1'b1, exp_id[0], efun(vw)});
      chk({tag, " no relaunch"}, starts, exp_starts);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, " done"}, {bus.resp_valid, bus.busy, bus.resp_err}, 3'b000);
  endtask

  initial begin
    tv_t        tbl[8];
    int         n, left[2], gap[2], got, cyc;
    bit         pend[2], prev_idle, w;
    logic [1:0] prev_req, eack;
    logic       last_m;
    vin_t       v;
    vout_t      eq0[$], eq1[$];
    int         gq[$];

    tbl[0] = '{2'b11, 1}; tbl[1] = '{2'b11, 0}; tbl[2] = '{2'b01, 0}; tbl[3] = '{2'b11, 1};
    tbl[4] = '{2'b10, 1}; tbl[5] = '{2'b11, 0}; tbl[6] = '{2'b10, 1}; tbl[7] = '{2'b11, 0};

    bus.req = 2'b00; bus.in0_flat = '0; bus.in1_flat = '0; bus.resp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset ctl", {bus.busy, bus.ack, bus.eng_start, bus.resp_valid, bus.resp_id, bus.resp_err}, '0);
    chk("reset eng_in", bus.eng_in_flat, '0);
    chk("reset resp_data", bus.resp_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job("single", 2'b01, 2'b00, 0, 40, 0, 0, 0, fillvec(16'h0100), mkvec(3));

    for (int i = 0; i < 8; i++)
      run_job($sformatf("tbl%0d", i), tbl[i].rq, 2'b00, tbl[i].exp_id, 3 + i, 0, 0, i % 3,
              mkvec(10 + 2*i), mkvec(11 + 2*i));

    for (int i = 0; i < 4; i++)
      run_job($sformatf("tie%0d", i), 2'b11, (i < 3) ? 2'b11 : 2'b00, (i % 2 == 0) ? 1 : 0,
              6, 0, 0, 0, mkvec(30 + 2*i), mkvec(31 + 2*i));

    run_job("bp0", 2'b01, 2'b10, 0, 10, 0, 0, 10, mkvec(40), mkvec(41));
    run_job("bp1", 2'b10, 2'b00, 1, 7, 0, 0, 0, mkvec(42), mkvec(43));

    run_job("sticky0", 2'b01, 2'b00, 0, 10, 0, 1, 0, mkvec(50), mkvec(51));
    run_job("sticky1", 2'b10, 2'b00, 1, 20, 20, 1, 0, mkvec(52), mkvec(53));
    run_job("sticky2", 2'b10, 2'b00, 1, 8, 0, 0, 0, mkvec(54), mkvec(55));

    // Reset while BUSY: the tie just granted 0, so a surviving last_grant would pick 1 next.
    eng_never = 1'b1;
    bus.in0_flat = mkvec(60); bus.in1_flat = mkvec(61); bus.req = 2'b11;
    @(negedge clk);
    chk("rst job ack", bus.ack, 2'b01);
    exp_starts++;
    bus.req = 2'b00;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ctl", {bus.busy, bus.ack, bus.eng_start, bus.resp_valid, bus.resp_id, bus.resp_err}, '0);
    chk("midrst eng_in", bus.eng_in_flat, '0);
    chk("midrst resp_data", bus.resp_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eng_never = 1'b0;
    @(negedge clk);
    chk("midrst quiet", {bus.resp_valid, bus.busy}, 2'b00);
    run_job("post-rst tie", 2'b11, 2'b00, 0, 5, 0, 0, 0, mkvec(62), mkvec(63));

`ifdef LAYER2_ARB_TIMEOUT_EN
    eng_never = 1'b1;
    bus.in0_flat = mkvec(70); bus.in1_flat = mkvec(71); bus.req = 2'b10;
    @(negedge clk);
    chk("tmo ack", bus.ack, 2'b10);
    exp_starts++;
    bus.req = 2'b00;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("tmo latency", n, 65);
    chk("tmo id/err", {bus.resp_id, bus.resp_err}, 2'b11);
    chk("tmo data", bus.resp_data, '0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("tmo clear", {bus.resp_valid, bus.resp_err, bus.busy}, 3'b000);
    eng_never = 1'b0;
`endif

    // Randomized traffic: grants from the round-robin rule, data from per-requester queues.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eng_rand = 1'b1; eng_sticky = 1'b0; eng_hold = 0;
    left = '{20, 20}; gap = '{0, 1}; pend = '{1'b0, 1'b0};
    prev_req = 2'b00; prev_idle = 1'b0; last_m = 1'b1; got = 0; cyc = 0;
    while (got < 40 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      eack = 2'b00;
      if (prev_idle && prev_req != 2'b00) begin
        w = (prev_req == 2'b11) ? ~last_m : prev_req[1];
        eack = w ? 2'b10 : 2'b01;
        last_m = w;
        gq.push_back(int'(w));
      end
      chk("rnd ack", bus.ack, eack);
      if (bus.resp_valid === 1'b1) begin
        if (gq.size() == 0) chk("rnd spurious resp", bus.resp_valid, 1'b0);
        else begin
          chk("rnd resp_id", bus.resp_id, gq[0]);
          if (gq[0] == 0) chk("rnd data0", bus.resp_data, (eq0.size() > 0) ? eq0[0] : '0);
          else            chk("rnd data1", bus.resp_data, (eq1.size() > 0) ? eq1[0] : '0);
        end
        bus.resp_ready = ($urandom_range(0, 2) != 0);
        if (bus.resp_ready && gq.size() > 0) begin
          if (gq[0] == 0 && eq0.size() > 0) void'(eq0.pop_front());
          if (gq[0] == 1 && eq1.size() > 0) void'(eq1.pop_front());
          void'(gq.pop_front());
          got++;
        end
      end else bus.resp_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && bus.ack[r]) begin
          pend[r] = 1'b0;
          left[r]--;
          gap[r] = $urandom_range(0, 3);
          if (r == 0) bus.in0_flat = rndvec(); else bus.in1_flat = rndvec();
        end
        if (!pend[r] && left[r] > 0) begin
          if (gap[r] == 0) begin
            v = rndvec();
            if (r == 0) begin bus.in0_flat = v; eq0.push_back(efun(v)); end
            else        begin bus.in1_flat = v; eq1.push_back(efun(v)); end
            pend[r] = 1'b1;
          end else gap[r]--;
        end
      end
      bus.req = {pend[1], pend[0]};
      prev_req = bus.req;
      prev_idle = (bus.busy === 1'b0);
    end
    chk("rnd completed", got, 40);
    chk("rnd queues empty", eq0.size() + eq1.size() + gq.size(), 0);
    bus.req = 2'b00;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
